// File: rtl/gorev_birimi_core.sv
// Per-pixel task unit: pass/negate/threshold/brighten, 256-bin histogram with readout,
// and histogram equalization (present only when GORUNTU_HE_EN is defined).
module gorev_birimi_core #(
  parameter int GEN = 320,
  parameter int YUK = 240
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        basla,
  input  logic        etkin_i,
  input  logic [7:0]  pixel_i,
  input  logic        stal_i,
  input  logic [2:0]  gorev_i,
  output logic        etkin_o,
  output logic [23:0] pixel_o
);

  localparam int          N     = GEN * YUK;
  localparam logic [16:0] N_SON = 17'(N - 1);

  typedef enum logic [1:0] {BOS, ISLE, YAZ} durum_t;

  durum_t      durum_q, durum_d;
  logic [2:0]  gorev_q;
  logic [16:0] pix_cnt;
  logic [7:0]  oku_k;

  // Handshake: a pixel is accepted on an edge where the unit is in ISLE, etkin_i=1 and
  // stal_i=0; an output word is consumed on an edge where etkin_o=1 and stal_i=0.
  // While stal_i=1 nothing advances and etkin_o/pixel_o hold.
  logic kabul, okuma;
  assign kabul = (durum_q == ISLE) && etkin_i && !stal_i;
  assign okuma = (durum_q == YAZ) && !stal_i;

  // Stage 1: registered pixel/bin address plus the RAM read data that goes with it.
  logic        s1_v, s1_h, s1_r;
  logic [7:0]  s1_a;
  logic [2:0]  s1_g;
  logic [16:0] rd_q;

  logic [16:0] hist_mem [256];
  logic [7:0]  rd_adr;
  logic        yaz_en;
  logic [16:0] yaz_d;

  always_comb begin
    durum_d = durum_q;
    case (durum_q)
      BOS:     if (basla) durum_d = ISLE;
      ISLE:    if (kabul && pix_cnt == N_SON) durum_d = (gorev_q == 3'd4) ? YAZ : BOS;
      YAZ:     if (okuma && oku_k == 8'hFF) durum_d = BOS;
      default: durum_d = BOS;
    endcase
  end

  assign rd_adr = (durum_q == YAZ) ? oku_k : pixel_i;
  assign yaz_en = !stal_i && (s1_h || s1_r);
  assign yaz_d  = s1_h ? (rd_q + 17'd1) : 17'd0;

  // The write of the previous pixel is forwarded into the read so equal neighbours both count.
  always_ff @(posedge clk_i) begin
    if (yaz_en) hist_mem[s1_a] <= yaz_d;
    if (!stal_i) rd_q <= (yaz_en && s1_a == rd_adr) ? yaz_d : hist_mem[rd_adr];
  end

`ifdef GORUNTU_HE_EN
  localparam int          CW    = $clog2(N + 1);
  localparam int unsigned MAP_K = (255 * 1048576 + N - 1) / N;

  logic [7:0]     map_mem [256];
  logic [7:0]     map_q;
  logic [CW-1:0]  cdf, cdf_nx;
  logic [CW+27:0] map_prod;
  logic [CW+7:0]  map_sh;
  logic [7:0]     map_v;

  // Bin 0 restarts the running sum, so no separate clear is needed between readouts.
  always_comb begin
    cdf_nx   = ((s1_a == 8'd0) ? '0 : cdf) + CW'(rd_q);
    map_prod = (CW+28)'(cdf_nx) * (CW+28)'(MAP_K);
    map_sh   = map_prod[CW+27:20];
    map_v    = (|map_sh[CW+7:8]) ? 8'hFF : map_sh[7:0];
  end

  always_ff @(posedge clk_i) begin
    if (!stal_i && s1_r) map_mem[s1_a] <= map_v;
    if (!stal_i) map_q <= map_mem[pixel_i];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)                 cdf <= '0;
    else if (!stal_i && s1_r)  cdf <= cdf_nx;
  end
`endif

  logic [7:0] v;
  always_comb begin
    v = s1_a;
    case (s1_g)
      3'd1: v = ~s1_a;
      3'd2: v = s1_a[7] ? 8'hFF : 8'h00;
      3'd3: v = (s1_a >= 8'd224) ? 8'hFF : (s1_a + 8'd32);
`ifdef GORUNTU_HE_EN
      3'd5: v = map_q;
`endif
      default: v = s1_a;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      durum_q <= BOS;
      gorev_q <= 3'd0;
      pix_cnt <= 17'd0;
      oku_k   <= 8'd0;
      s1_v    <= 1'b0;
      s1_h    <= 1'b0;
      s1_r    <= 1'b0;
      s1_a    <= 8'd0;
      s1_g    <= 3'd0;
      etkin_o <= 1'b0;
      pixel_o <= 24'd0;
    end else begin
      durum_q <= durum_d;
      if (durum_q == BOS && basla) begin
        gorev_q <= gorev_i;
        pix_cnt <= 17'd0;
      end else if (kabul) begin
        pix_cnt <= pix_cnt + 17'd1;
      end
      if (okuma) oku_k <= oku_k + 8'd1;
      if (!stal_i) begin
        s1_v    <= kabul && (gorev_q != 3'd4);
        s1_h    <= kabul && (gorev_q == 3'd4);
        s1_r    <= okuma;
        s1_a    <= rd_adr;
        s1_g    <= gorev_q;
        etkin_o <= s1_v || s1_r;
        if (s1_v)      pixel_o <= {v, v, v};
        else if (s1_r) pixel_o <= {7'd0, rd_q};
      end
    end
  end

endmodule

// File: tb/tb_gorev_birimi_core.sv
// Scoreboard bench for gorev_birimi_core on a reduced 32x24 image.
module tb_gorev_birimi_core;
  localparam int GEN = 32;
  localparam int YUK = 24;
  localparam int N   = GEN * YUK;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        basla = 1'b0;
  logic        etkin_i = 1'b0;
  logic        stal_i = 1'b0;
  logic [7:0]  pixel_i = 8'd0;
  logic [2:0]  gorev_i = 3'd0;
  logic        etkin_o;
  logic [23:0] pixel_o;

  gorev_birimi_core #(.GEN(GEN), .YUK(YUK)) dut (
    .clk_i(clk), .rst_i(rst), .basla(basla), .etkin_i(etkin_i), .pixel_i(pixel_i),
    .stal_i(stal_i), .gorev_i(gorev_i), .etkin_o(etkin_o), .pixel_o(pixel_o)
  );

  always #5 clk = ~clk;

  logic [23:0] exp_q[$];
  logic [23:0] mon_e;
  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;
  int model_hist[256];
`ifdef GORUNTU_HE_EN
  logic [7:0] model_map[256];
`endif

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every consumed word is popped and compared.
  always @(negedge clk) begin
    if (!rst && mon_en && etkin_o && !stal_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL out_extra actual=%06h required=none", pixel_o);
      end else begin
        mon_e = exp_q.pop_front();
        if (pixel_o !== mon_e) begin
          failures++;
          $display("FAIL out_word actual=%06h required=%06h", pixel_o, mon_e);
        end
      end
    end
  end

  task automatic check_eq(input string name, input logic [23:0] act, input logic [23:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%06h required=%06h", name, act, req);
    end
  endtask

  function automatic logic [7:0] pix_of(input int mode, input int i, input logic [7:0] c);
    return (mode == 0) ? 8'(i % 256) : c;
  endfunction

  function automatic logic [7:0] ref_v(input logic [2:0] g, input logic [7:0] p);
    int s;
    case (g)
      3'd1: return 8'd255 - p;
      3'd2: return (p >= 8'd128) ? 8'd255 : 8'd0;
      3'd3: begin
        s = int'(p) + 32;
        return (s > 255) ? 8'd255 : 8'(s);
      end
`ifdef GORUNTU_HE_EN
      3'd5: return model_map[p];
`endif
      default: return p;
    endcase
  endfunction

  task automatic start(input logic [2:0] g);
    basla = 1'b1;
    gorev_i = g;
    tick;
    basla = 1'b0;
    gorev_i = ~g;
  endtask

  task automatic send_image(input logic [2:0] g, input int mode, input logic [7:0] c,
                            input int stall_every, input int count);
    logic [7:0] p, r;
    for (int i = 0; i < count; i++) begin
      p = pix_of(mode, i, c);
      etkin_i = 1'b1;
      pixel_i = p;
      if (stall_every > 0 && (i % stall_every) == stall_every - 1) begin
        stal_i = 1'b1;
        tick;
        stal_i = 1'b0;
      end
      if (g != 3'd4) begin
        r = ref_v(g, p);
        exp_q.push_back({r, r, r});
      end
      // A start pulse mid-image must be ignored.
      if (i == count / 2) begin
        basla = 1'b1;
        gorev_i = 3'd4;
      end
      tick;
      basla = 1'b0;
      if (i % 7 == 3) begin
        etkin_i = 1'b0;
        tick;
      end
    end
    etkin_i = 1'b0;
  endtask

  task automatic hist_prep(input int mode, input logic [7:0] c);
`ifdef GORUNTU_HE_EN
    longint kk, cdf, m;
`endif
    for (int k = 0; k < 256; k++) model_hist[k] = 0;
    for (int i = 0; i < N; i++) model_hist[pix_of(mode, i, c)]++;
    for (int k = 0; k < 256; k++) exp_q.push_back(24'(model_hist[k]));
`ifdef GORUNTU_HE_EN
    kk = (64'd255 * 64'd1048576 + longint'(N) - 1) / longint'(N);
    cdf = 0;
    for (int k = 0; k < 256; k++) begin
      cdf = cdf + longint'(model_hist[k]);
      m = (cdf * kk) >>> 20;
      model_map[k] = (m > 255) ? 8'd255 : 8'(m);
    end
`endif
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 4000) begin
      tick;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_timeout actual=%0d required=0 words left", name, exp_q.size());
      exp_q.delete();
    end
    check_eq({name, "_valid_low"}, {23'd0, etkin_o}, 24'd0);
    repeat (4) tick;
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) tick;
    check_eq("rst_valid", {23'd0, etkin_o}, 24'd0);
    check_eq("rst_pixel", pixel_o, 24'd0);
    rst = 1'b0;
    tick;

    // Bring the histogram RAM to a known all-zero state via one full readout.
    start(3'd4);
    send_image(3'd4, 0, 8'd0, 0, N);
    repeat (300) tick;
    mon_en = 1'b1;

    start(3'd0); send_image(3'd0, 0, 8'd0, 2, N); drain("pass");
    start(3'd1); send_image(3'd1, 1, 8'h10, 0, N); drain("neg");
    start(3'd2); send_image(3'd2, 0, 8'd0, 3, N); drain("esik");
    start(3'd3); send_image(3'd3, 0, 8'd0, 0, N); drain("parlak");
    start(3'd6); send_image(3'd6, 0, 8'd0, 5, N); drain("code6");

    // Histogram of a constant image, with a 10-cycle stall in the middle of readout.
    hist_prep(1, 8'h55);
    start(3'd4);
    send_image(3'd4, 1, 8'h55, 0, N);
    repeat (12) tick;
    stal_i = 1'b1;
    tick;
    begin
      logic        hv;
      logic [23:0] hp;
      hv = etkin_o;
      hp = pixel_o;
      check_eq("yaz_valid", {23'd0, etkin_o}, 24'd1);
      for (int j = 0; j < 9; j++) begin
        tick;
        check_eq("stall_hold_v", {23'd0, etkin_o}, {23'd0, hv});
        check_eq("stall_hold_p", pixel_o, hp);
      end
    end
    stal_i = 1'b0;
    drain("hist55");

    start(3'd5); send_image(3'd5, 0, 8'd0, 4, N); drain("he_step");

    hist_prep(0, 8'd0);
    start(3'd4); send_image(3'd4, 0, 8'd0, 0, N); drain("hist_mod");
    rst = 1'b1;
    repeat (2) tick;
    rst = 1'b0;
    tick;
    start(3'd5); send_image(3'd5, 0, 8'd0, 0, N); drain("he_mod");

    // Abort a pass run with reset, then run a full pass normally.
    start(3'd0);
    send_image(3'd0, 0, 8'd0, 0, 100);
    rst = 1'b1;
    tick;
    check_eq("abort_valid", {23'd0, etkin_o}, 24'd0);
    check_eq("abort_pixel", pixel_o, 24'd0);
    exp_q.delete();
    rst = 1'b0;
    tick;
    check_eq("abort_idle", {23'd0, etkin_o}, 24'd0);
    start(3'd0); send_image(3'd0, 0, 8'd0, 3, N); drain("after_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
